// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding unit: operand-source selects and FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic {
    StIdle,
    StStall
  } hazState_e;

endpackage

// File: rtl/fwd_select.sv
// Single-operand forwarding select: EX/MEM beats MEM/WB, register 0 is never forwarded.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] exMemRd,
  input  logic                  exMemRegwrite,
  input  logic [REG_ADDR_W-1:0] memWbRd,
  input  logic                  memWbRegwrite,
  output logic [1:0]            sel
);

  logic exHit;
  logic wbHit;

  assign exHit = exMemRegwrite && (exMemRd != '0) && (exMemRd == rs);
  assign wbHit = memWbRegwrite && (memWbRd != '0) && (memWbRd == rs);

  always_comb begin
    sel = FWD_RF;
    if (exHit) begin
      sel = FWD_MEM;
    end else if (wbHit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding plus load-use stall FSM for a 5-stage pipeline.
// Optional build macro STALL_COUNTER_EN adds a saturating 32-bit stall_count output.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned LOAD_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_ex_rs,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] if_id_rs,
  input  logic [REG_ADDR_W-1:0]         id_ex_rd,
  input  logic                          id_ex_memread,
  input  logic [REG_ADDR_W-1:0]         ex_mem_rd,
  input  logic                          ex_mem_regwrite,
  input  logic [REG_ADDR_W-1:0]         mem_wb_rd,
  input  logic                          mem_wb_regwrite,
  input  logic                          hold,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic                          stall,
  output logic                          bubble
`ifdef STALL_COUNTER_EN
  ,
  output logic [31:0]                   stall_count
`endif
);

  // The first stall cycle happens in IDLE, so STALL covers the remaining LOAD_LAT-1.
  localparam bit         MultiCycle = (LOAD_LAT > 1);
  localparam logic [2:0] CntInit    = MultiCycle ? 3'(LOAD_LAT - 2) : 3'd0;

  hazState_e            stateQ;
  logic      [2:0]      cntQ;
  logic      [NUM_SRC-1:0] rsMatch;
  logic                 hazard;

  for (genvar g = 0; g < NUM_SRC; g++) begin : gen_src
    fwd_select #(
      .REG_ADDR_W(REG_ADDR_W)
    ) u_fwd_select (
      .rs            (id_ex_rs[g*REG_ADDR_W +: REG_ADDR_W]),
      .exMemRd       (ex_mem_rd),
      .exMemRegwrite (ex_mem_regwrite),
      .memWbRd       (mem_wb_rd),
      .memWbRegwrite (mem_wb_regwrite),
      .sel           (fwd_sel[2*g +: 2])
    );

    assign rsMatch[g] = (if_id_rs[g*REG_ADDR_W +: REG_ADDR_W] == id_ex_rd);
  end

  assign hazard = id_ex_memread && (id_ex_rd != '0) && (|rsMatch);

  // Hazards seen while in STALL are ignored; stall is already high there.
  assign stall  = (stateQ == StStall) || hazard;
  assign bubble = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= StIdle;
      cntQ   <= 3'd0;
    end else if (!hold) begin
      case (stateQ)
        StIdle: begin
          if (hazard && MultiCycle) begin
            stateQ <= StStall;
            cntQ   <= CntInit;
          end
        end
        StStall: begin
          if (cntQ == 3'd0) begin
            stateQ <= StIdle;
          end else begin
            cntQ <= cntQ - 3'd1;
          end
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

`ifdef STALL_COUNTER_EN
  logic [31:0] stallCntQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCntQ <= 32'd0;
    end else if (stall && !hold && (stallCntQ != 32'hFFFF_FFFF)) begin
      stallCntQ <= stallCntQ + 32'd1;
    end
  end

  assign stall_count = stallCntQ;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit (LOAD_LAT=3): forwarding table, random sweep, stall sequences.
module tb_hazard_forward_unit;
  import hazard_pkg::*;

  localparam int unsigned RW  = 5;
  localparam int unsigned NS  = 2;
  localparam int unsigned LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*RW-1:0]  id_ex_rs;
  logic [NS*RW-1:0]  if_id_rs;
  logic [RW-1:0]     id_ex_rd;
  logic              id_ex_memread;
  logic [RW-1:0]     ex_mem_rd;
  logic              ex_mem_regwrite;
  logic [RW-1:0]     mem_wb_rd;
  logic              mem_wb_regwrite;
  logic              hold;
  logic [2*NS-1:0]   fwd_sel;
  logic              stall;
  logic              bubble;
`ifdef STALL_COUNTER_EN
  logic [31:0]       stall_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  hazard_forward_unit #(
    .REG_ADDR_W(RW),
    .NUM_SRC   (NS),
    .LOAD_LAT  (LAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_ex_rs        (id_ex_rs),
    .if_id_rs        (if_id_rs),
    .id_ex_rd        (id_ex_rd),
    .id_ex_memread   (id_ex_memread),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_regwrite (ex_mem_regwrite),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .hold            (hold),
    .fwd_sel         (fwd_sel),
    .stall           (stall),
    .bubble          (bubble)
`ifdef STALL_COUNTER_EN
    ,
    .stall_count     (stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] exRd;
    logic       exWr;
    logic [4:0] wbRd;
    logic       wbWr;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [3:0] expSel;
  } fwdVec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: each operand picks the youngest in-flight writer, ignoring register 0.
  function automatic logic [3:0] refFwd(input logic [4:0] rs[2], input logic [4:0] exRd,
                                        input logic exWr, input logic [4:0] wbRd,
                                        input logic wbWr);
    logic [3:0] r = 4'b0;
    for (int op = 0; op < 2; op++) begin
      if (rs[op] == 0) continue;
      if (exWr && exRd == rs[op]) r[2*op +: 2] = 2'b10;
      else if (wbWr && wbRd == rs[op]) r[2*op +: 2] = 2'b01;
    end
    return r;
  endfunction

  task automatic clearInputs();
    id_ex_rs = '0; if_id_rs = '0; id_ex_rd = '0; id_ex_memread = 1'b0;
    ex_mem_rd = '0; ex_mem_regwrite = 1'b0; mem_wb_rd = '0; mem_wb_regwrite = 1'b0;
    hold = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load id_ex_rd=4 with if_id_rs1=4; the load leaves ID/EX after the first edge.
  task automatic runSeq(input string name, input logic [7:0] holdPat, input logic [7:0] expPat,
                        input int n, output int highCycles, output int countedCycles);
    highCycles = 0;
    countedCycles = 0;
    id_ex_rd = 5'd4; id_ex_memread = 1'b1; if_id_rs = {5'd4, 5'd1};
    for (int k = 0; k < n; k++) begin
      hold = holdPat[k];
      #1;
      check($sformatf("%s stall c%0d", name, k), 32'(stall), 32'(expPat[k]));
      check($sformatf("%s bubble c%0d", name, k), 32'(bubble), 32'(expPat[k]));
      if (stall) highCycles++;
      if (stall && !hold) countedCycles++;
      tick();
      if (k == 0) id_ex_memread = 1'b0;
    end
    hold = 1'b0;
  endtask

  initial begin
    fwdVec_t    tbl[8];
    logic [4:0] rsArr[2];
    int         hi, cnt;

    tbl[0] = '{"ex hit op0",      5'd5,  1'b1, 5'd0,  1'b0, 5'd5,  5'd0,  4'b0010};
    tbl[1] = '{"both hit op1",    5'd7,  1'b1, 5'd7,  1'b1, 5'd0,  5'd7,  4'b1000};
    tbl[2] = '{"wb only op1",     5'd7,  1'b0, 5'd7,  1'b1, 5'd0,  5'd7,  4'b0100};
    tbl[3] = '{"r0 never fwd",    5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  5'd0,  4'b0000};
    tbl[4] = '{"split ops",       5'd3,  1'b1, 5'd9,  1'b1, 5'd9,  5'd3,  4'b1001};
    tbl[5] = '{"no regwrite",     5'd3,  1'b0, 5'd3,  1'b0, 5'd3,  5'd3,  4'b0000};
    tbl[6] = '{"r31 op0",         5'd31, 1'b1, 5'd31, 1'b1, 5'd31, 5'd30, 4'b0010};
    tbl[7] = '{"ex both ops",     5'd12, 1'b1, 5'd12, 1'b0, 5'd12, 5'd12, 4'b1010};

    clearInputs();
    rst = 1'b1;
    #1;
    check("reset fwd_sel", 32'(fwd_sel), 32'h0);
    check("reset stall", 32'(stall), 32'h0);
    check("reset bubble", 32'(bubble), 32'h0);
    check("reset state", 32'(dut.stateQ), 32'(StIdle));
`ifdef STALL_COUNTER_EN
    check("reset stall_count", stall_count, 32'h0);
`endif
    // Combinational hazard still shows through an asserted reset.
    id_ex_rd = 5'd6; id_ex_memread = 1'b1; if_id_rs = {5'd2, 5'd6};
    #1;
    check("hazard under rst", 32'(stall), 32'h1);
    clearInputs();
    doReset();

    foreach (tbl[i]) begin
      @(negedge clk);
      ex_mem_rd = tbl[i].exRd; ex_mem_regwrite = tbl[i].exWr;
      mem_wb_rd = tbl[i].wbRd; mem_wb_regwrite = tbl[i].wbWr;
      id_ex_rs = {tbl[i].rs1, tbl[i].rs0};
      #1;
      check(tbl[i].name, 32'(fwd_sel), 32'(tbl[i].expSel));
      check({tbl[i].name, " no stall"}, 32'(stall), 32'h0);
    end

    // Random sweep with hold high keeps the FSM parked in IDLE.
    hold = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic expHaz;
      @(negedge clk);
      rsArr[0] = 5'($urandom_range(0, 7));
      rsArr[1] = 5'($urandom_range(0, 7));
      ex_mem_rd = 5'($urandom_range(0, 7)); ex_mem_regwrite = 1'($urandom);
      mem_wb_rd = 5'($urandom_range(0, 7)); mem_wb_regwrite = 1'($urandom);
      id_ex_rs = {rsArr[1], rsArr[0]};
      if_id_rs = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_ex_rd = 5'($urandom_range(0, 7)); id_ex_memread = 1'($urandom);
      #1;
      expHaz = id_ex_memread && (id_ex_rd != 0) &&
               ((if_id_rs[4:0] == id_ex_rd) || (if_id_rs[9:5] == id_ex_rd));
      check($sformatf("rand fwd %0d", i), 32'(fwd_sel),
            32'(refFwd(rsArr, ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite)));
      check($sformatf("rand stall %0d", i), 32'(stall), 32'(expHaz));
      check($sformatf("rand bubble %0d", i), 32'(bubble), 32'(expHaz));
    end
    clearInputs();
    doReset();

    runSeq("lat3", 8'b0000_0000, 8'b0000_0111, 6, hi, cnt);
    check("lat3 high cycles", 32'(hi), 32'd3);

    doReset();
    runSeq("lat3 hold", 8'b0000_0110, 8'b0001_1111, 7, hi, cnt);
    check("hold high cycles", 32'(hi), 32'd5);
    check("hold counted cycles", 32'(cnt), 32'd3);
`ifdef STALL_COUNTER_EN
    check("hold stall_count", stall_count, 32'd3);
`endif

    // Reset in the second STALL cycle aborts the stall at once.
    doReset();
    id_ex_rd = 5'd4; id_ex_memread = 1'b1; if_id_rs = {5'd4, 5'd1};
    #1;
    check("rst seq c0 stall", 32'(stall), 32'h1);
    tick();
    id_ex_memread = 1'b0;
    check("rst seq c1 stall", 32'(stall), 32'h1);
    tick();
    check("rst seq c2 stall", 32'(stall), 32'h1);
    rst = 1'b1;
    #1;
    check("rst abort stall", 32'(stall), 32'h0);
    check("rst abort bubble", 32'(bubble), 32'h0);
    check("rst abort state", 32'(dut.stateQ), 32'(StIdle));
    tick();
    rst = 1'b0;
    tick();
    check("after rst stall", 32'(stall), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
